// File: rtl/time_of_day_counter_pkg.sv
// time_of_day_counter_pkg: BCD time types, field limits and helper functions shared by the time-of-day counter.
//   bcd2_t    : packed pair of BCD nibbles, [1] = tens, [0] = units
//   bcd_valid : both nibbles are decimal digits and the value does not exceed max
//   bcd_inc   : modulo-(max+1) BCD increment
package clock_pkg;

    typedef logic [1:0][3:0] bcd2_t;

    localparam bcd2_t SEC_MAX  = 8'h59;
    localparam bcd2_t MIN_MAX  = 8'h59;
    localparam bcd2_t HOUR_MAX = 8'h23;

    // With both nibbles decimal, raw unsigned ordering equals numeric ordering.
    function automatic logic bcd_valid(bcd2_t v, bcd2_t max);
        return v[1] <= 4'd9 && v[0] <= 4'd9 && v <= max;
    endfunction

    function automatic bcd2_t bcd_inc(bcd2_t v, bcd2_t max);
        return v == max ? bcd2_t'(8'h00) :
               v[0] == 4'd9 ? bcd2_t'({v[1] + 4'd1, 4'd0}) :
               bcd2_t'({v[1], v[0] + 4'd1});
    endfunction

endpackage

// File: rtl/time_of_day_counter_if.sv
// time_of_day_counter_if: strobe, load, alarm and time/pulse signals of the time-of-day counter.
//   master : setting UI / divider side, drives strobes and load/alarm values, observes time and pulses
//   slave  : the counter itself
interface time_of_day_counter_if;
    import clock_pkg::*;

    logic  tick_in;
    logic  set_en;
    bcd2_t set_hh;
    bcd2_t set_mm;
    bcd2_t set_ss;
    logic  alarm_en;
    bcd2_t alarm_hh;
    bcd2_t alarm_mm;
    bcd2_t hh;
    bcd2_t mm;
    bcd2_t ss;
    logic  min_tick;
    logic  hour_tick;
    logic  day_tick;
    logic  alarm_hit;
    logic  set_err;

    modport master (
        output tick_in, set_en, set_hh, set_mm, set_ss, alarm_en, alarm_hh, alarm_mm,
        input  hh, mm, ss, min_tick, hour_tick, day_tick, alarm_hit, set_err
    );

    modport slave (
        input  tick_in, set_en, set_hh, set_mm, set_ss, alarm_en, alarm_hh, alarm_mm,
        output hh, mm, ss, min_tick, hour_tick, day_tick, alarm_hit, set_err
    );

endinterface

// File: rtl/time_of_day_counter_bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD modulo counter with synchronous load.
//   clk_in, reset : clock, asynchronous active-high reset to RESET_VAL
//   inc           : advance by one, wrapping MAX -> 00
//   load/load_val : synchronous load, takes priority over inc
//   value         : registered count
//   wrap          : combinational carry-out, high when inc arrives at MAX
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter bcd2_t MAX       = SEC_MAX,
    parameter bcd2_t RESET_VAL = 8'h00
) (
    input  logic  clk_in,
    input  logic  reset,
    input  logic  inc,
    input  logic  load,
    input  bcd2_t load_val,
    output bcd2_t value,
    output logic  wrap
);

    assign wrap = inc && value == MAX;

    always_ff @(posedge clk_in or posedge reset)
        if (reset)
            value <= RESET_VAL;
        else if (load)
            value <= load_val;
        else if (inc)
            value <= bcd_inc(value, MAX);

endmodule

// File: rtl/time_of_day_counter.sv
// time_of_day_counter: 24-hour BCD hh:mm:ss counter advanced by tick strobes, with validated load, rollover pulses and alarm match.
//   clk_in, reset : clock, asynchronous active-high reset to RESET_HH:RESET_MM:RESET_SS
//   bus           : slave side of time_of_day_counter_if (strobes, load, alarm, time and pulse outputs)
module time_of_day_counter
    import clock_pkg::*;
#(
    parameter bcd2_t RESET_HH = 8'h00,
    parameter bcd2_t RESET_MM = 8'h00,
    parameter bcd2_t RESET_SS = 8'h00
) (
    input logic                  clk_in,
    input logic                  reset,
    time_of_day_counter_if.slave bus
);

    logic  set_ok;
    logic  load;
    logic  adv;
    logic  ss_wrap;
    logic  mm_wrap;
    logic  hh_wrap;
    logic  alarm_match;
    bcd2_t next_mm;
    bcd2_t next_hh;

    assign set_ok = bcd_valid(bus.set_hh, HOUR_MAX) && bcd_valid(bus.set_mm, MIN_MAX) &&
                    bcd_valid(bus.set_ss, SEC_MAX);
    assign load   = bus.set_en && set_ok;
    // Any load request, accepted or rejected, swallows a coincident tick.
    assign adv    = bus.tick_in && !bus.set_en;

    bcd_mod_counter #(.MAX(SEC_MAX), .RESET_VAL(RESET_SS)) u_ss (
        .clk_in(clk_in), .reset(reset), .inc(adv), .load(load), .load_val(bus.set_ss),
        .value(bus.ss), .wrap(ss_wrap)
    );

    bcd_mod_counter #(.MAX(MIN_MAX), .RESET_VAL(RESET_MM)) u_mm (
        .clk_in(clk_in), .reset(reset), .inc(ss_wrap), .load(load), .load_val(bus.set_mm),
        .value(bus.mm), .wrap(mm_wrap)
    );

    bcd_mod_counter #(.MAX(HOUR_MAX), .RESET_VAL(RESET_HH)) u_hh (
        .clk_in(clk_in), .reset(reset), .inc(mm_wrap), .load(load), .load_val(bus.set_hh),
        .value(bus.hh), .wrap(hh_wrap)
    );

    // Seconds land on :00 only through ss_wrap, so the next minute is always the
    // incremented one there; the hour moves only when minutes wrap too.
    assign next_mm     = bcd_inc(bus.mm, MIN_MAX);
    assign next_hh     = mm_wrap ? bcd_inc(bus.hh, HOUR_MAX) : bus.hh;
    assign alarm_match = bus.alarm_en && ss_wrap && next_mm == bus.alarm_mm && next_hh == bus.alarm_hh;

    always_ff @(posedge clk_in or posedge reset)
        if (reset) begin
            bus.min_tick  <= 1'b0;
            bus.hour_tick <= 1'b0;
            bus.day_tick  <= 1'b0;
            bus.alarm_hit <= 1'b0;
            bus.set_err   <= 1'b0;
        end else begin
            bus.min_tick  <= ss_wrap;
            bus.hour_tick <= mm_wrap;
            bus.day_tick  <= hh_wrap;
            bus.alarm_hit <= alarm_match;
            bus.set_err   <= bus.set_en && !set_ok;
        end

endmodule

// File: doc/time_of_day_counter.md
# time_of_day_counter

Strobe consumer for the alarm-clock datapath: counts single-cycle `tick_in` strobes (nominally 1 Hz from the clock divider) into a 24-hour BCD time of day, hh:mm:ss. It accepts a synchronous time load from the setting UI, emits minute, hour and day rollover pulses, and flags an alarm match. Its outputs feed the display mux and the alarm controller.

## Interface
- `RESET_HH`, default 8'h00: BCD hours loaded on reset; must be a valid BCD value 00..23.
- `RESET_MM`, default 8'h00: BCD minutes loaded on reset; must be 00..59.
- `RESET_SS`, default 8'h00: BCD seconds loaded on reset; must be 00..59.
- `clk_in`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `tick_in`  in  1  one-cycle advance strobe; every cycle it is high counts as one second.
- `set_en`  in  1  one-cycle load request.
- `set_hh`, `set_mm`, `set_ss`  in  8 each  BCD load values.
- `alarm_en`  in  1  enables alarm compare.
- `alarm_hh`, `alarm_mm`  in  8 each  BCD alarm time.
- `hh`, `mm`, `ss`  out  8 each  current BCD time, registered.
- `min_tick`, `hour_tick`, `day_tick`  out  1  rollover pulses, registered.
- `alarm_hit`  out  1  one-cycle alarm pulse.
- `set_err`  out  1  one-cycle pulse for a rejected load.

## Operation
- Reset, asynchronous:
  - `hh`/`mm`/`ss` = `RESET_HH`/`RESET_MM`/`RESET_SS`.
  - All pulse outputs = 0.
- Tick, with `set_en` = 0:
  - `ss` increments in BCD: units 0..9, then tens 0..5.
  - 59 → 00 asserts `min_tick` and increments `mm` the same way.
  - `mm` 59 → 00 asserts `hour_tick` and increments `hh`.
  - `hh` counts 00..23; 23 → 00 asserts `day_tick`.
  - All carries ripple within the same cycle. 23:59:59 + tick gives 00:00:00 with `min_tick`, `hour_tick` and `day_tick` all high together.
- Load, on `set_en` = 1:
  - Each field is validated: every nibble ≤ 9, hh ≤ 23, mm ≤ 59, ss ≤ 59.
  - All valid: `hh`/`mm`/`ss` take the set values on the next edge.
  - Any field invalid: the whole load is dropped, time is unchanged and `set_err` pulses.
  - Loading never produces rollover pulses or `alarm_hit`.
- `set_en` and `tick_in` in the same cycle:
  - The load wins and the tick is discarded.
  - For an invalid load, the tick is also discarded (time holds).
- Alarm:
  - `alarm_hit` pulses in the cycle the time becomes alarm_hh:alarm_mm:00 through a tick, when `alarm_en` = 1.
  - The match is evaluated against the next-state value.
  - An invalid alarm time simply never matches.
- Time holds when neither `set_en` nor `tick_in` is asserted.

## Timing
- Latency: one cycle from the `tick_in`/`set_en` sample edge to updated outputs. Pulses are aligned with the new time value.
- Pulse width: exactly one cycle per causing event. Back-to-back ticks give back-to-back updates, with no dead cycles.
- Register boundary: no combinational path from inputs to outputs.
- Reset mid-operation: takes effect immediately and asynchronously. The first tick after release advances from the reset value.

## Structure
- Shared `clock_pkg`:
  - `bcd2_t` typedef: packed 8-bit pair of BCD nibbles.
  - Constants `SEC_MAX` = 8'h59, `MIN_MAX` = 8'h59, `HOUR_MAX` = 8'h23.
  - Function `bcd_valid(bcd2_t, bcd2_t max)`.
- Sub-module `bcd_mod_counter`, instantiated three times:
  - Parameter `MAX` (`bcd2_t`).
  - Inputs: `inc`, `load`, `load_val`.
  - Outputs: `value`, plus combinational `wrap` = `inc` && `value` == `MAX`.
- Top level: validation, load/tick priority, carry chaining, alarm compare and pulse registers.

## Test plan
- Reset with defaults, then 61 ticks → 00:01:01; `min_tick` high exactly on the tick 00:00:59 → 00:01:00.
- Load 23:59:58, two ticks → 23:59:59, then 00:00:00 with `min_tick`, `hour_tick` and `day_tick` asserted in the same single cycle.
- `set_en` with `set_mm` = 8'h6A → `set_err` pulses, time unchanged; `set_hh` = 8'h24 → rejected identically.
- `set_en` and `tick_in` together, loading 12:34:56 → output 12:34:56 (not :57); no pulses.
- `alarm_en` = 1, alarm 07:30; load 07:29:59, then tick → 07:30:00 with a one-cycle `alarm_hit`. Direct load of 07:30:00 → no `alarm_hit`.
- Assert `reset` mid-count at 05:06:07 → outputs return to the reset value without waiting for a clock edge; pulses low.
